// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver feeding a small first-word-fall-through FIFO.
// The RX pin is synchronised, frames are deserialised LSB-first, and each
// good byte is pushed into the FIFO. Sticky framing/overflow flags are kept
// until uart_clr_i.
// Optional feature: define UART_RX_PARITY_EN to add an even-parity bit
// between the data bits and the stop bit, plus the sticky uart_perr_o output.
module uart_rx #(
  parameter int CLK_FREQ        = 100000000,
  parameter int BAUD_RATE       = 115200,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic                     sys_clk_i,
  input  logic                     sys_rstn_i,
  input  logic                     uart_rx_i,
  input  logic                     uart_rd_i,
  input  logic                     uart_clr_i,
  output logic [7:0]               uart_dat_o,
  output logic                     uart_valid_o,
  output logic [FIFO_DEPTH_LOG2:0] uart_count_o,
  output logic                     uart_ferr_o,
  output logic                     uart_ovf_o
`ifdef UART_RX_PARITY_EN
  ,output logic                    uart_perr_o
`endif
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int DEPTH        = 1 << FIFO_DEPTH_LOG2;

  localparam logic [CNT_W-1:0]           BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]           HALF_LAST  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [FIFO_DEPTH_LOG2:0]   FULL_COUNT = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
`ifdef UART_RX_PARITY_EN
    ,ST_PARITY
`endif
  } state_t;

  logic rx_meta, rx_sync, rx_hist;
  logic fall_edge;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  clk_cnt_q, clk_cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              push;
  logic              ferr_set;
`ifdef UART_RX_PARITY_EN
  logic              perr_set;
  logic              perr_q;
`endif

  logic [7:0]                 mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   count_q;
  logic                       fifo_empty, fifo_full;
  logic                       pop_ok, push_ok, ovf_set;
  logic                       ferr_q, ovf_q;

  // Two-flop synchroniser plus a history flop for falling-edge detection; idles high.
  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_hist <= 1'b1;
    end else begin
      rx_meta <= uart_rx_i;
      rx_sync <= rx_meta;
      rx_hist <= rx_sync;
    end
  end

  assign fall_edge = rx_hist & ~rx_sync;

  // Frame FSM state, bit timer, bit index and shift register.
  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      state_q   <= ST_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  // Next-state logic: start bit checked at mid-bit, then one sample per bit period.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q + CNT_W'(1);
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    push      = 1'b0;
    ferr_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_set  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        clk_cnt_d = '0;
        if (fall_edge) begin
          state_d   = ST_START;
          bit_cnt_d = '0;
        end
      end
      ST_START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          state_d   = rx_sync ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rx_sync, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          perr_set  = ^{shift_q, rx_sync};
          state_d   = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          state_d   = ST_IDLE;
          if (rx_sync) begin
            push = 1'b1;
          end else begin
            ferr_set = 1'b1;
          end
        end
      end
      default: begin
        clk_cnt_d = '0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_COUNT);
  assign pop_ok     = uart_rd_i & ~fifo_empty;
  assign push_ok    = push & (~fifo_full | pop_ok);
  assign ovf_set    = push & fifo_full & ~pop_ok;

  // FIFO pointers and occupancy; a simultaneous pop frees room for the push.
  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage has no reset; only the pointers define which entries are live.
  always_ff @(posedge sys_clk_i) begin
    if (push_ok) begin
      mem[wr_ptr] <= shift_q;
    end
  end

  // Sticky error flags; a new error in the same cycle as a clear keeps the flag set.
  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      ferr_q <= 1'b0;
      ovf_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q <= 1'b0;
`endif
    end else begin
      ferr_q <= (ferr_q & ~uart_clr_i) | ferr_set;
      ovf_q  <= (ovf_q & ~uart_clr_i) | ovf_set;
`ifdef UART_RX_PARITY_EN
      perr_q <= (perr_q & ~uart_clr_i) | perr_set;
`endif
    end
  end

  assign uart_dat_o   = fifo_empty ? 8'h00 : mem[rd_ptr];
  assign uart_valid_o = ~fifo_empty;
  assign uart_count_o = count_q;
  assign uart_ferr_o  = ferr_q;
  assign uart_ovf_o   = ovf_q;
`ifdef UART_RX_PARITY_EN
  assign uart_perr_o  = perr_q;
`endif

endmodule
